// File: rtl/dbg_reg_dumper_if.sv
// Register-dump stream bundle: control, register-file debug read port
// and the valid/ready byte channel toward the sink.
interface dbg_reg_dumper_if;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [4:0]  dbg_reg_adrs;
  logic [31:0] dbg_reg_q;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;

  modport master (
    input  start,
    input  abort,
    input  dbg_reg_q,
    input  tx_ready,
    output dbg_reg_adrs,
    output tx_valid,
    output tx_data,
    output busy,
    output done
  );

  modport slave (
    output start,
    output abort,
    output dbg_reg_q,
    output tx_ready,
    input  dbg_reg_adrs,
    input  tx_valid,
    input  tx_data,
    input  busy,
    input  done
  );
endinterface

// File: rtl/dbg_reg_dumper.sv
// Walks the CPU register file through its debug port and streams each
// register as a 5-byte frame {adrs, q[31:24], q[23:16], q[15:8], q[7:0]}.
module dbg_reg_dumper #(
  parameter int unsigned FIRST_REG     = 0,
  parameter int unsigned LAST_REG      = 31,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic              clk_cpu,
  input logic              reset,
  dbg_reg_dumper_if.master bus
);

  localparam int unsigned CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [4:0]    FIRST    = 5'(FIRST_REG);
  localparam logic [4:0]    LAST     = 5'(LAST_REG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] snap;
  logic [2:0]  idx;
  logic [4:0]  adrs;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;
  logic [7:0]  nxt_byte;
  logic        xfer;

  assign bus.dbg_reg_adrs = adrs;
  assign bus.tx_valid     = tx_valid;
  assign bus.tx_data      = tx_data;
  assign bus.busy         = busy;
  assign bus.done         = done;

  assign xfer = tx_valid && bus.tx_ready;

  // Byte that follows the one currently presented at idx.
  always_comb begin
    nxt_byte = 8'h00;
    unique case (idx)
      3'd0:    nxt_byte = snap[31:24];
      3'd1:    nxt_byte = snap[23:16];
      3'd2:    nxt_byte = snap[15:8];
      3'd3:    nxt_byte = snap[7:0];
      default: nxt_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      snap     <= '0;
      idx      <= '0;
      adrs     <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.abort && state != S_IDLE) begin
        state    <= S_IDLE;
        tx_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              adrs  <= FIRST;
              cnt   <= CNT_LOAD;
              busy  <= 1'b1;
              state <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (cnt == '0) begin
              state <= S_CAPTURE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_CAPTURE: begin
            snap     <= bus.dbg_reg_q;
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_data  <= {3'b000, adrs};
            state    <= S_SEND;
          end
          S_SEND: begin
            if (xfer) begin
              if (idx == 3'd4) begin
                tx_valid <= 1'b0;
                // Compare before increment so LAST_REG=31 never wraps.
                if (adrs == LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
                end else begin
                  adrs  <= adrs + 5'd1;
                  cnt   <= CNT_LOAD;
                  state <= S_SETTLE;
                end
              end else begin
                idx     <= idx + 3'd1;
                tx_data <= nxt_byte;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
